// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared types and constants for the PWM configuration scheduler
package pwm_sched_pkg;
  typedef enum logic {R_IDLE = 1'b0, R_HOLD = 1'b1} ramp_state_t;
  localparam logic FIELD_DUTY = 1'b0;
  localparam logic FIELD_FREQ = 1'b1;
  localparam int DUTY_RST = 0;
  localparam int FREQ_RST = 1;
endpackage

// File: rtl/pwm_ramp_engine.sv
// pwm_ramp_engine: duty ramp FSM with hold counter and saturating step toward target
module pwm_ramp_engine
  import pwm_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_target,
  input  logic [DATA_W-1:0] i_step,
  input  logic [DATA_W-1:0] i_hold,
  input  logic [DATA_W-1:0] i_duty,
  input  logic              i_abort,
  input  logic              i_step_grant,
  output logic              o_step_req,
  output logic [DATA_W-1:0] o_step_val,
  output logic              o_busy,
  output logic              o_done
);
  ramp_state_t       r_state, w_next;
  logic [DATA_W-1:0] r_target, r_step, r_hold, r_cnt;
  logic              r_done;
  logic              w_start, w_step, w_up;
  logic [DATA_W:0]   w_diff;

  // distance to target in one extra bit so the saturation compare never wraps
  always_comb begin
    w_up       = r_target > i_duty;
    w_diff     = w_up ? {1'b0, r_target} - {1'b0, i_duty} : {1'b0, i_duty} - {1'b0, r_target};
    o_step_val = (w_diff <= {1'b0, r_step}) ? r_target : w_up ? i_duty + r_step : i_duty - r_step;
    w_start    = (r_state == R_IDLE) && i_start && !i_abort;
    w_step     = (r_state == R_HOLD) && i_step_grant && (r_cnt == '0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= w_next;
  end

  // next state: a host duty write aborts, reaching target returns to idle
  always_comb begin
    w_next = i_abort ? R_IDLE :
             (w_start && (i_target != i_duty)) ? R_HOLD :
             (w_step && (o_step_val == r_target)) ? R_IDLE : r_state;
  end

  // outputs derived from state
  always_comb begin
    o_busy     = r_state == R_HOLD;
    o_step_req = (r_state == R_HOLD) && (r_cnt == '0);
    o_done     = r_done;
  end

  // latch ramp parameters at start, count hold boundaries, pulse done on arrival
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_target <= '0;
      r_step   <= '0;
      r_hold   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_start && (i_target == i_duty)) || (w_step && (o_step_val == r_target) && !i_abort);
      if (w_start) begin
        r_target <= i_target;
        r_step   <= (i_step == '0) ? DATA_W'(1) : i_step;
        r_hold   <= i_hold;
        r_cnt    <= i_hold;
      end else if ((r_state == R_HOLD) && i_step_grant) begin
        r_cnt <= (r_cnt != '0) ? r_cnt - DATA_W'(1) : r_hold;
      end
    end
  end
endmodule

// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: applies host writes and ramp steps to PWM config at period boundaries
module pwm_cfg_sched
  import pwm_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  input  logic              host_field,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              ramp_start,
  input  logic [DATA_W-1:0] ramp_target,
  input  logic [DATA_W-1:0] ramp_step,
  input  logic [DATA_W-1:0] ramp_hold,
  input  logic              period_end,
  output logic [DATA_W-1:0] duty_cycle,
  output logic [DATA_W-1:0] freq_div,
  output logic              cfg_valid,
  output logic              ramp_busy,
  output logic              ramp_done
);
  logic              r_full, r_field, r_valid;
  logic [DATA_W-1:0] r_data, r_duty, r_freq;
  logic              w_accept, w_abort, w_grant, w_step_req;
  logic [DATA_W-1:0] w_step_val;

  // the ramp only gets a boundary the host slot does not claim
  always_comb begin
    w_accept   = host_valid && !r_full;
    w_abort    = w_accept && (host_field == FIELD_DUTY);
    w_grant    = period_end && !r_full;
    host_ready = !r_full;
    duty_cycle = r_duty;
    freq_div   = r_freq;
    cfg_valid  = r_valid;
  end

  pwm_ramp_engine #(.DATA_W(DATA_W)) u_ramp (
    .clk          (clk),
    .rst          (rst),
    .i_start      (ramp_start),
    .i_target     (ramp_target),
    .i_step       (ramp_step),
    .i_hold       (ramp_hold),
    .i_duty       (r_duty),
    .i_abort      (w_abort),
    .i_step_grant (w_grant),
    .o_step_req   (w_step_req),
    .o_step_val   (w_step_val),
    .o_busy       (ramp_busy),
    .o_done       (ramp_done)
  );

  // host slot fill/drain and one config update per boundary, host before ramp
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full  <= 1'b0;
      r_field <= FIELD_DUTY;
      r_data  <= '0;
      r_duty  <= DATA_W'(DUTY_RST);
      r_freq  <= DATA_W'(FREQ_RST);
      r_valid <= 1'b0;
    end else begin
      r_valid <= period_end && (r_full || w_step_req);
      r_full  <= w_accept ? 1'b1 : period_end ? 1'b0 : r_full;
      r_field <= w_accept ? host_field : r_field;
      r_data  <= w_accept ? host_data : r_data;
      if (period_end && r_full && (r_field == FIELD_DUTY)) r_duty <= r_data;
      else if (w_grant && w_step_req) r_duty <= w_step_val;
      if (period_end && r_full && (r_field == FIELD_FREQ)) r_freq <= (r_data == '0) ? DATA_W'(1) : r_data;
    end
  end
endmodule

// File: tb/tb_pwm_cfg_sched.sv
// tb_pwm_cfg_sched: table-driven cycle vectors plus hand sequences for reset and busy-start cases
module tb_pwm_cfg_sched;
  typedef struct {
    logic       rst, hv, hf;
    logic [7:0] hd;
    logic       rs;
    logic [7:0] rt, st, ho;
    logic       pe;
    logic [7:0] duty, freq;
    logic       v, rdy, busy, done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_valid = 1'b0, host_field = 1'b0;
  logic [7:0] host_data = '0;
  logic       host_ready;
  logic       ramp_start = 1'b0;
  logic [7:0] ramp_target = '0, ramp_step = '0, ramp_hold = '0;
  logic       period_end = 1'b0;
  logic [7:0] duty_cycle, freq_div;
  logic       cfg_valid, ramp_busy, ramp_done;
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  pwm_cfg_sched #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_field(host_field), .host_data(host_data), .host_ready(host_ready),
    .ramp_start(ramp_start), .ramp_target(ramp_target), .ramp_step(ramp_step), .ramp_hold(ramp_hold),
    .period_end(period_end),
    .duty_cycle(duty_cycle), .freq_div(freq_div), .cfg_valid(cfg_valid),
    .ramp_busy(ramp_busy), .ramp_done(ramp_done)
  );

  task automatic run(input vec_t r, input string name);
    logic [19:0] got, exp;
    rst = r.rst; host_valid = r.hv; host_field = r.hf; host_data = r.hd;
    ramp_start = r.rs; ramp_target = r.rt; ramp_step = r.st; ramp_hold = r.ho;
    period_end = r.pe;
    @(posedge clk);
    #1;
    got = {duty_cycle, freq_div, cfg_valid, host_ready, ramp_busy, ramp_done};
    exp = {r.duty, r.freq, r.v, r.rdy, r.busy, r.done};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got duty=%h freq=%h v=%b rdy=%b busy=%b done=%b, want duty=%h freq=%h v=%b rdy=%b busy=%b done=%b",
               name, duty_cycle, freq_div, cfg_valid, host_ready, ramp_busy, ramp_done,
               r.duty, r.freq, r.v, r.rdy, r.busy, r.done);
    end
  endtask

  initial begin
    // rst hv hf hd  rs rt st ho pe | duty freq v rdy busy done
    tbl.push_back('{0,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h01,0,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h01,0,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h01,0,1,0,0});
    // host duty 0x40, boundary 5 cycles later
    tbl.push_back('{1,1,0,8'h40,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,0,0,0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h40,8'h01,1,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h40,8'h01,0,1,0,0});
    // freq 5 then freq 0 stored as 1
    tbl.push_back('{1,1,1,8'h05,0,8'h00,8'h0,8'h0,0, 8'h40,8'h01,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h40,8'h05,1,1,0,0});
    tbl.push_back('{1,1,1,8'h00,0,8'h00,8'h0,8'h0,0, 8'h40,8'h05,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h40,8'h01,1,1,0,0});
    // write on the same cycle as period_end waits a boundary
    tbl.push_back('{1,1,1,8'h22,0,8'h00,8'h0,8'h0,1, 8'h40,8'h01,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h40,8'h01,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h40,8'h22,1,1,0,0});
    // duty back to 0
    tbl.push_back('{1,1,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h40,8'h22,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h22,1,1,0,0});
    // up-ramp 0 -> 0x0A step 4 hold 1
    tbl.push_back('{1,0,0,8'h00,1,8'h0A,8'h4,8'h1,0, 8'h00,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h04,8'h22,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h04,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h08,8'h22,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h08,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h0A,8'h22,1,1,0,1});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h0A,8'h22,0,1,0,0});
    // down-ramp 0x0A -> 0 step 4 hold 1
    tbl.push_back('{1,0,0,8'h00,1,8'h00,8'h4,8'h1,0, 8'h0A,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h0A,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h06,8'h22,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h06,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h02,8'h22,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h02,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h22,1,1,0,1});
    // start with target equal to duty: done only
    tbl.push_back('{1,0,0,8'h00,1,8'h00,8'h4,8'h0,0, 8'h00,8'h22,0,1,0,1});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h22,0,1,0,0});
    // step 0 behaves as 1
    tbl.push_back('{1,0,0,8'h00,1,8'h02,8'h0,8'h0,0, 8'h00,8'h22,0,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h01,8'h22,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h02,8'h22,1,1,0,1});
    // freq write pending at a step boundary defers the step
    tbl.push_back('{1,0,0,8'h00,1,8'h08,8'h4,8'h0,0, 8'h02,8'h22,0,1,1,0});
    tbl.push_back('{1,1,1,8'h33,0,8'h00,8'h0,8'h0,0, 8'h02,8'h22,0,0,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h02,8'h33,1,1,1,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h06,8'h33,1,1,1,0});
    // host duty mid-ramp aborts without done
    tbl.push_back('{1,1,0,8'h10,0,8'h00,8'h0,8'h0,0, 8'h06,8'h33,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h10,8'h33,1,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h10,8'h33,0,1,0,0});
    // simultaneous start and host duty write: host wins
    tbl.push_back('{1,1,0,8'h20,1,8'h50,8'h1,8'h0,0, 8'h10,8'h33,0,0,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h20,8'h33,1,1,0,0});
    tbl.push_back('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h20,8'h33,0,1,0,0});
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("row%0d", i));

    // reset mid-ramp with the slot full
    run('{1,0,0,8'h00,1,8'h80,8'h1,8'h3,0, 8'h20,8'h33,0,1,1,0}, "mid_start");
    run('{1,1,1,8'h44,0,8'h00,8'h0,8'h0,0, 8'h20,8'h33,0,0,1,0}, "mid_fill");
    run('{0,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,1,0,0}, "mid_reset");
    run('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h00,8'h01,0,1,0,0}, "post_reset_pe");
    run('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,0, 8'h00,8'h01,0,1,0,0}, "post_reset_idle");

    // ramp_start while busy is ignored
    run('{1,0,0,8'h00,1,8'h03,8'h1,8'h0,0, 8'h00,8'h01,0,1,1,0}, "busy_start0");
    run('{1,0,0,8'h00,1,8'h01,8'h3,8'h0,0, 8'h00,8'h01,0,1,1,0}, "busy_start1");
    run('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h01,8'h01,1,1,1,0}, "busy_step1");
    run('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h02,8'h01,1,1,1,0}, "busy_step2");
    run('{1,0,0,8'h00,0,8'h00,8'h0,8'h0,1, 8'h03,8'h01,1,1,0,1}, "busy_step3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_cfg_sched.md
Name: pwm_cfg_sched

Overview:
- Scheduler between the UART command path and pwm_ctrl. It owns the live duty_cycle/freq_div registers and arbitrates two requesters: host writes from the command decoder, and an internal duty-ramp engine.
- All changes are applied only at PWM period boundaries, with host writes taking priority over ramp steps.
- Each applied change raises a one-cycle cfg_valid toward pwm_ctrl.

Parameters:
- DATA_W, 8, width of duty, freq, target, step and hold values.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-low (design resets on posedge clk while rst==0).
- host_valid  in  1  host write request.
- host_field  in  1  field select: 0 = duty, 1 = freq.
- host_data  in  DATA_W  value to write.
- host_ready  out  1  host slot empty; a write is accepted when host_valid && host_ready.
- ramp_start  in  1  pulse that starts a duty ramp.
- ramp_target  in  DATA_W  final duty value.
- ramp_step  in  DATA_W  duty increment per step; 0 is treated as 1.
- ramp_hold  in  DATA_W  number of extra period boundaries between steps; 0 means step every boundary.
- period_end  in  1  one-cycle pulse from pwm_ctrl at end of each PWM period.
- duty_cycle  out  DATA_W  live duty to PWM.
- freq_div  out  DATA_W  live frequency divider to PWM.
- cfg_valid  out  1  one-cycle pulse when duty_cycle or freq_div changed.
- ramp_busy  out  1  ramp in progress.
- ramp_done  out  1  one-cycle pulse when ramp reaches target.

Behaviour:
- Reset values (rst==0 at a clk edge):
  - duty_cycle=0, freq_div=1, cfg_valid=0, host_ready=1, ramp_busy=0, ramp_done=0.
  - Host slot is emptied and ramp FSM goes to R_IDLE.
  - This holds mid-operation: pending writes and ramps are discarded, with no pulses.
- Host slot (one entry: field, data, full flag):
  - host_ready = !full.
  - An accepted write sets full at the next edge.
  - A write accepted on the same cycle as period_end is NOT applied at that boundary; it waits for the next one.
- Apply rule: at most one update per period_end, with host > ramp.
  - On period_end with full=1: write the slot value to the selected register and clear full.
  - A pending ramp step at that boundary is deferred (hold counter unchanged).
  - Registers and cfg_valid update at the edge after the period_end cycle, i.e. 1-cycle latency from period_end. Output values change in the same cycle cfg_valid is high.
  - A freq write of 0 is stored as 1.
- Ramp FSM states: R_IDLE, R_HOLD.
  - R_IDLE on ramp_start:
    - Latch target, step (0→1) and hold; hold_cnt=hold.
    - If target==duty_cycle: pulse ramp_done next cycle and stay in R_IDLE, with no cfg_valid.
    - Else go to R_HOLD and set ramp_busy=1.
  - ramp_start while busy is ignored. Inputs are sampled only at start.
  - R_HOLD on period_end (host slot empty):
    - If hold_cnt!=0, decrement it.
    - Else step duty toward target, reload hold_cnt and pulse cfg_valid.
    - If the new duty==target: pulse ramp_done (same cycle as cfg_valid), clear ramp_busy, go to R_IDLE.
  - Step arithmetic uses DATA_W+1 bits and saturates at target (no overshoot, no wrap):
    - up: if target-duty <= step then target, else duty+step.
    - down: if duty-target <= step then target, else duty-step.
- Abort: an accepted host duty write while ramp_busy forces R_IDLE and ramp_busy=0 at the next edge. There is no ramp_done pulse, and the host value is applied at the next boundary. A host freq write does not abort the ramp.
- Simultaneous ramp_start and an accepted host duty write in R_IDLE: the host wins and ramp_start is dropped.

Decomposition:
- Package pwm_sched_pkg holds:
  - ramp state enum (R_IDLE, R_HOLD);
  - FIELD_DUTY=0, FIELD_FREQ=1;
  - DUTY_RST=0, FREQ_RST=1.
- Sub-module pwm_ramp_engine contains the ramp FSM, hold counter and saturating step. It exposes step_req/step_val to the top and takes a step_grant from it.
- The top holds the host slot, arbitration and the output registers.

Test Plan:
- Reset, then 3 period_end pulses with no requests → duty=0, freq=1, cfg_valid never asserted, host_ready=1.
- Host writes duty=0x40, period_end 5 cycles later → duty_cycle=0x40 and a 1-cycle cfg_valid at period_end+1. host_ready is 0 from accept until the cycle after that boundary.
- Host writes freq=0 → freq_div=1. Host write on the same cycle as period_end → applied only at the following period_end.
- Ramp from duty 0x00, target 0x0A, step 4, hold 1 → duty 0x04, 0x08, 0x0A on every 2nd period_end. ramp_done coincides with the third cfg_valid. Repeat as a down-ramp from 0x0A to 0x00 with step 4 → 0x06, 0x02, 0x00.
- Ramp busy plus host freq write pending at a step boundary → freq applied and step deferred one boundary. A host duty write mid-ramp → ramp_busy drops, no ramp_done, host value applied.
- Assert rst low mid-ramp with the slot full → all outputs return to reset values, and the next period_end produces no cfg_valid.
